// File: rtl/mem_requester.sv
// rtl/mem_requester.sv - single-outstanding CPU memory initiator for the ROM/RAM grant resolver
//
// Accepts one fetch, load or store at a time (priority store > load > fetch).
// It raises the matching request line, waits for the grant and runs the
// transfer. It then drops the request and waits for the grant to fall.
// Optional macro MEM_TIMEOUT_EN: abort REQ after TIMEOUT clocks and pulse err.
//
// Ports:
//   clk, reset (sync, active-low)
//   CPU side   : fetch_req/fetch_addr, load_req/store_req/ls_addr/store_data,
//                ready, fetch_data/fetch_valid, load_data/load_valid,
//                store_done, err
//   resolver   : rom_rd/ram_rd/ram_wr out, rom_garant/ram_garant_rd/ram_garant_wr in
//   memory     : rom_addr/rom_q, ram_addr/ram_q/ram_d/ram_we
module mem_requester #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              load_req,
  input  logic              store_req,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              ready,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              store_done,
  output logic              err,
  output logic              rom_rd,
  output logic              ram_rd,
  output logic              ram_wr,
  input  logic              rom_garant,
  input  logic              ram_garant_rd,
  input  logic              ram_garant_wr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] rom_q,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we
);

  localparam int CNT_W = $clog2(TIMEOUT + RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_FETCH, OP_LOAD, OP_STORE} op_t;

  state_t            state, state_next;
  op_t               op, op_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              accept;
  logic              grant;
  logic              cap_fetch, cap_load, done_next;
  logic              active;

  // Request lines are decoded from state so they rise on the accept edge and
  // fall on the edge that leaves XFER (or on reset) with no extra register.
  assign active   = (state == REQ) || (state == XFER);
  assign ready    = (state == IDLE);
  assign rom_rd   = active && (op == OP_FETCH);
  assign ram_rd   = active && (op == OP_LOAD);
  assign ram_wr   = active && (op == OP_STORE);
  assign ram_we   = (state == XFER) && (op == OP_STORE);
  assign rom_addr = addr_q;
  assign ram_addr = addr_q;
  assign ram_d    = data_q;

`ifdef MEM_TIMEOUT_EN
  logic err_q, err_next;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_next = state;
    op_next    = op;
    cnt_next   = cnt;
    accept     = 1'b0;
    cap_fetch  = 1'b0;
    cap_load   = 1'b0;
    done_next  = 1'b0;
    grant      = 1'b0;
`ifdef MEM_TIMEOUT_EN
    err_next   = 1'b0;
`endif
    // Only the grant belonging to the latched op is ever looked at.
    case (op)
      OP_FETCH: grant = rom_garant;
      OP_LOAD:  grant = ram_garant_rd;
      OP_STORE: grant = ram_garant_wr;
      default:  grant = 1'b0;
    endcase

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (store_req) begin
          op_next = OP_STORE;
          accept  = 1'b1;
        end else if (load_req) begin
          op_next = OP_LOAD;
          accept  = 1'b1;
        end else if (fetch_req) begin
          op_next = OP_FETCH;
          accept  = 1'b1;
        end
        if (accept) state_next = REQ;
      end
      REQ: begin
        if (grant) begin
          state_next = XFER;
          cnt_next   = '0;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_next = REL;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
`endif
      end
      XFER: begin
        if (op == OP_STORE) begin
          // The strobe lives exactly one XFER cycle; done marks its end.
          done_next  = 1'b1;
          state_next = REL;
        end else if (cnt == CNT_W'(RD_LAT - 1)) begin
          cap_fetch  = (op == OP_FETCH);
          cap_load   = (op == OP_LOAD);
          state_next = REL;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      REL: begin
        if (!grant) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      op          <= OP_NONE;
      cnt         <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      fetch_data  <= '0;
      load_data   <= '0;
      fetch_valid <= 1'b0;
      load_valid  <= 1'b0;
      store_done  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      op          <= op_next;
      cnt         <= cnt_next;
      fetch_valid <= cap_fetch;
      load_valid  <= cap_load;
      store_done  <= done_next;
`ifdef MEM_TIMEOUT_EN
      err_q       <= err_next;
`endif
      if (accept) begin
        addr_q <= (op_next == OP_FETCH) ? fetch_addr : ls_addr;
        data_q <= store_data;
      end
      if (cap_fetch) fetch_data <= rom_q;
      if (cap_load)  load_data  <= ram_q;
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// tb/tb_mem_requester.sv - directed table-driven bench for mem_requester
module tb_mem_requester;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fetch_req = 1'b0, load_req = 1'b0, store_req = 1'b0;
  logic [7:0] fetch_addr = '0, ls_addr = '0, store_data = '0;
  logic       ready, fetch_valid, load_valid, store_done, err;
  logic [7:0] fetch_data, load_data;
  logic       rom_rd, ram_rd, ram_wr, ram_we;
  logic       rom_garant = 1'b0, ram_garant_rd = 1'b0, ram_garant_wr = 1'b0;
  logic [7:0] rom_addr, ram_addr, ram_d;
  logic [7:0] rom_q = '0, ram_q = '0;

  always #5 clk = ~clk;

  mem_requester #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .load_req(load_req), .store_req(store_req), .ls_addr(ls_addr), .store_data(store_data),
    .ready(ready), .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .load_data(load_data), .load_valid(load_valid), .store_done(store_done), .err(err),
    .rom_rd(rom_rd), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .rom_garant(rom_garant), .ram_garant_rd(ram_garant_rd), .ram_garant_wr(ram_garant_wr),
    .rom_addr(rom_addr), .ram_addr(ram_addr), .rom_q(rom_q), .ram_q(ram_q),
    .ram_d(ram_d), .ram_we(ram_we)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // line: 0 = rom_rd, 1 = ram_rd, 2 = ram_wr. gd < 0 means never grant.
  typedef struct {
    logic       f, l, s;
    logic [7:0] fa, la, sd, q;
    int         gd, hold, line, req_cyc, lat, exp_err;
  } vec_t;

  task automatic drive_grant(input int line, input logic g);
    rom_garant    = (line == 0) && g;
    ram_garant_rd = (line == 1) && g;
    ram_garant_wr = (line == 2) && g;
  endtask

  // Called at a negedge with ready=1; returns at the negedge where ready is back.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc[3];
    int lat = 0, fv = 0, lv = 0, sdn = 0, er = 0, we = 0, bad = 0, gcnt = 0, hcnt = 0;
    int pulse;
    logic [7:0] got = '0;
    logic [2:0] lines;
    logic       g = 1'b0;
    logic       cur;
    bit         done = 0;
    cyc[0] = 0; cyc[1] = 0; cyc[2] = 0;
    fetch_req = v.f; load_req = v.l; store_req = v.s;
    fetch_addr = v.fa; ls_addr = v.la; store_data = v.sd;
    rom_q = v.q; ram_q = v.q;
    @(posedge clk); #1;
    fetch_req = 0; load_req = 0; store_req = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (ready) begin
        done = 1;
      end else begin
        lat++;
        lines = {ram_wr, ram_rd, rom_rd};
        for (int i = 0; i < 3; i++) if (lines[i]) cyc[i]++;
        if (rom_rd && rom_addr !== v.fa) bad++;
        if ((ram_rd || ram_wr) && ram_addr !== v.la) bad++;
        if (fetch_valid) begin fv++; got = fetch_data; end
        if (load_valid)  begin lv++; got = load_data; end
        if (store_done) sdn++;
        if (err) er++;
        if (ram_we) begin
          we++;
          if (ram_d !== v.sd || ram_addr !== v.la) bad++;
        end
        cur = lines[v.line];
        if (cur) begin
          if (v.gd >= 0) begin
            if (gcnt == v.gd) g = 1'b1; else gcnt++;
          end
        end else if (g) begin
          if (hcnt == v.hold) g = 1'b0; else hcnt++;
        end
        drive_grant(v.line, g);
      end
    end
    drive_grant(v.line, 1'b0);
    check($sformatf("v%0d_ready_back", idx), done, 1);
    check($sformatf("v%0d_req_cycles", idx), cyc[v.line], v.req_cyc);
    check($sformatf("v%0d_other_lines", idx), cyc[(v.line + 1) % 3] + cyc[(v.line + 2) % 3], 0);
    check($sformatf("v%0d_latency", idx), lat, v.lat);
    check($sformatf("v%0d_addr_data", idx), bad, 0);
    check($sformatf("v%0d_err", idx), er, v.exp_err);
    pulse = v.exp_err ? 0 : 1;
    check($sformatf("v%0d_fetch_valid", idx), fv, (v.line == 0) ? pulse : 0);
    check($sformatf("v%0d_load_valid", idx), lv, (v.line == 1) ? pulse : 0);
    check($sformatf("v%0d_ram_we", idx), we, (v.line == 2) ? pulse : 0);
    check($sformatf("v%0d_store_done", idx), sdn, (v.line == 2) ? pulse : 0);
    if (v.line != 2 && !v.exp_err) check($sformatf("v%0d_rdata", idx), got, v.q);
  endtask

  vec_t vecs[7];
  int   bad;

  initial begin
    //          f  l  s  fa     la     sd     q      gd hold line req lat err
    vecs[0] = '{1, 0, 0, 8'h10, 8'h00, 8'h00, 8'hA5, 0, 0, 0, 2, 3, 0};
    vecs[1] = '{1, 1, 0, 8'h05, 8'h22, 8'h00, 8'h3C, 0, 0, 1, 2, 3, 0};
    vecs[2] = '{0, 0, 1, 8'h00, 8'h30, 8'h7F, 8'h00, 0, 0, 2, 2, 3, 0};
    vecs[3] = '{0, 1, 0, 8'h00, 8'h40, 8'h00, 8'h81, 2, 0, 1, 4, 5, 0};
    vecs[4] = '{0, 1, 0, 8'h00, 8'h41, 8'h00, 8'h99, 0, 4, 1, 2, 7, 0};
    vecs[5] = '{1, 1, 1, 8'h01, 8'h12, 8'h5A, 8'h11, 0, 0, 2, 2, 3, 0};
    vecs[6] = '{1, 0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 0, 0, 3, 4, 0};

    repeat (3) @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_outputs",
          {rom_rd, ram_rd, ram_wr, ram_we, fetch_valid, load_valid, store_done, err,
           fetch_data, load_data, rom_addr, ram_addr, ram_d}, 0);
    reset = 1'b1;
    @(negedge clk);

    // Grants seen in IDLE must not start anything.
    bad = 0;
    rom_garant = 1; ram_garant_rd = 1; ram_garant_wr = 1;
    repeat (3) begin
      @(negedge clk);
      if (!ready || rom_rd || ram_rd || ram_wr || ram_we) bad++;
    end
    rom_garant = 0; ram_garant_rd = 0; ram_garant_wr = 0;
    @(negedge clk);
    check("idle_grant_ignored", bad, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset during XFER of a load aborts with no valid pulse.
    ls_addr = 8'h50; ram_q = 8'h77; load_req = 1;
    @(posedge clk); #1; load_req = 0;
    @(negedge clk); ram_garant_rd = 1;
    @(negedge clk);
    check("rst_mid_in_xfer", ram_rd, 1);
    reset = 0;
    @(negedge clk);
    check("rst_mid_lines", {rom_rd, ram_rd, ram_wr, ram_we}, 0);
    check("rst_mid_ready", ready, 1);
    bad = load_valid ? 1 : 0;
    ram_garant_rd = 0; reset = 1;
    repeat (4) begin
      @(negedge clk);
      if (load_valid) bad++;
    end
    check("rst_mid_no_valid", bad, 0);

`ifdef MEM_TIMEOUT_EN
    begin
      vec_t t;
      t = '{0, 0, 1, 8'h00, 8'h33, 8'h44, 8'h00, -1, 0, 2, 15, 16, 1};
      run_vec(t, 7);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_requester.md
Name: mem_requester

Overview:
- Client-side initiator for the ROM/RAM grant resolver.
- Accepts one CPU memory operation at a time: instruction fetch from ROM, data load from RAM, or data store to RAM.
- Raises the matching request line, waits for the grant, then runs the transfer. It releases the request and waits for the grant to drop before accepting the next operation.
- Sits between the CPU core's fetch/load-store stage and the resolver plus memory ports.

Parameters:
- ADDR_W, 8: ROM/RAM address width.
- DATA_W, 8: data word width.
- RD_LAT, 1: synchronous memory read latency in clocks, range 1..3.
- TIMEOUT, 15: clocks in REQ before abort; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset; reset==0 at a posedge resets the block.
- fetch_req  in  1  fetch request; sampled only when ready=1.
- fetch_addr  in  ADDR_W  ROM address.
- load_req  in  1  load request.
- store_req  in  1  store request.
- ls_addr  in  ADDR_W  RAM address for load/store.
- store_data  in  DATA_W  write data.
- ready  out  1  block idle; a request is accepted this cycle.
- fetch_data  out  DATA_W  captured ROM word.
- fetch_valid  out  1  one-cycle pulse; fetch_data valid.
- load_data  out  DATA_W  captured RAM word.
- load_valid  out  1  one-cycle pulse.
- store_done  out  1  one-cycle pulse.
- err  out  1  one-cycle pulse on timeout abort; tied 0 without macro.
- rom_rd, ram_rd, ram_wr  out  1 each  request lines to the resolver.
- rom_garant, ram_garant_rd, ram_garant_wr  in  1 each  grants from the resolver; they change on negedge.
- rom_addr, ram_addr  out  ADDR_W  memory addresses.
- rom_q, ram_q  in  DATA_W  memory read data.
- ram_d  out  DATA_W  write data.
- ram_we  out  1  RAM write strobe.

Behaviour:
- Reset values: all outputs 0 except ready=1; state IDLE; latched op/addr/data cleared.
- Reset mid-operation aborts immediately:
  - request lines and ram_we drop at that edge;
  - no valid/done pulse is produced.
- States: IDLE, REQ, XFER, REL.
- IDLE, entry and arbitration:
  - ready=1.
  - Priority store > load > fetch.
  - On the accept edge, latch op, address and data. Go to REQ, with exactly one request line high from that edge.
  - Simultaneous requests: only the winner is accepted. Losers are ignored; the CPU must re-present them.
- REQ:
  - Hold the request line and address.
  - When the grant matching the op is sampled 1, go to XFER with a counter of 0.
  - Grants for other ops are ignored.
- XFER, read ops:
  - Count RD_LAT clocks.
  - On the final one, capture rom_q/ram_q into fetch_data/load_data and pulse the matching valid for one cycle.
  - Drop the request line on the same edge and go to REL.
- XFER, store:
  - ram_we=1 for exactly one cycle with ram_d/ram_addr stable.
  - store_done pulses on the edge that ends the strobe.
  - Drop ram_wr and go to REL.
- REL:
  - Request lines stay 0.
  - Wait until the matching grant is sampled 0, then go to IDLE (ready=1).
  - This guarantees no back-to-back request before the resolver frees.
- Minimum throughput, RD_LAT=1, grant after one negedge:
  - accept at edge 0;
  - XFER at edge 1;
  - valid pulse after edge 2;
  - ready again after edge 3.
- Data outputs hold their last captured value until the next capture.
- Addresses/ram_d remain driven with latched values outside IDLE; they are don't-care in IDLE.
- Grant sampled 1 in IDLE is ignored.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - REQ counts clocks.
  - If the grant is still 0 after TIMEOUT clocks, drop the request and pulse err for one cycle.
  - The op is discarded with no valid/done pulse, and the block goes to REL.
- Undefined: REQ waits indefinitely and err is constant 0.

Test Plan:
- Fetch, addr 0x10, rom_q=0xA5, grant one negedge after rom_rd -> rom_rd high 2 cycles; fetch_valid one pulse with fetch_data=0xA5; ready back 3 cycles after accept.
- Load 0x22 and fetch 0x05 asserted in the same cycle -> load accepted (ram_rd only, rom_rd stays 0); load_valid with ram_q value; fetch must be re-presented.
- Store 0x7F to addr 0x30 -> exactly one ram_we cycle with ram_addr=0x30, ram_d=0x7F; store_done one pulse; ram_wr low before IDLE.
- Load with grant held high 4 extra cycles after ram_rd drops -> block stays in REL (ready=0) until the grant is 0; no second ram_rd.
- reset=0 during XFER of a load -> next edge: all request lines 0, ready=1, load_valid never pulses.
- With MEM_TIMEOUT_EN and TIMEOUT=15, ram_garant_wr never asserted on a store -> ram_wr drops after 15 cycles; err one pulse; no store_done; ram_we never 1.
